// File: rtl/arbitro_pkg.sv
// Shared definitions for the two-lane round-robin arbiter.
//   state_t            : arbiter FSM encoding (IDLE / RUN / HOLD)
//   DATA_WIDTH_DEFAULT : default width of a data word
//   LANE0 / LANE1      : lane identifiers, also used as priority values
package arbitro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,  // no lane has data
    ST_RUN  = 2'b01,  // words are being granted
    ST_HOLD = 2'b10   // data waiting but downstream asked for a pause
  } state_t;

  localparam int DATA_WIDTH_DEFAULT = 8;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

endpackage : arbitro_pkg

// File: rtl/arbitro_mux2x1_contador_sat.sv
// Saturating up-counter used for per-lane grant statistics.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset (0 = clear count)
//   inc   : count one event this cycle
//   count : current count, holds at all-ones until reset
module contador_sat #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  // NOTE: reset is sampled on the clock edge only, so it sits inside the
  // edge-triggered block rather than in its sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule : contador_sat

// File: rtl/arbitro_mux2x1.sv
// Work-conserving round-robin arbiter sharing one output lane between two
// first-word-fall-through FIFOs. An empty lane is skipped, so a single busy
// lane is served every cycle; with both busy the grants alternate.
//   clk, reset          : clock, synchronous active-low reset
//   fifo0/1_empty       : per-lane FIFO empty flags (request = !empty)
//   fifo0/1_data        : per-lane FIFO head words
//   pause               : downstream almost-full, blocks new grants at once
//   pop0/1              : combinational FIFO read strobes (one-hot or zero)
//   data_out, valid_out : registered granted word and its qualifier
//   lane_out            : registered source lane of data_out
//   idle                : registered, high while the FSM is in IDLE
//   grants0/1           : saturating per-lane grant counters
module arbitro_mux2x1
  import arbitro_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo0_empty,
  input  logic                  fifo1_empty,
  input  logic [DATA_WIDTH-1:0] fifo0_data,
  input  logic [DATA_WIDTH-1:0] fifo1_data,
  input  logic                  pause,
  output logic                  pop0,
  output logic                  pop1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  lane_out,
  output logic                  idle,
  output logic [CNT_WIDTH-1:0]  grants0,
  output logic [CNT_WIDTH-1:0]  grants1
);

  state_t state;
  state_t state_nxt;
  logic   prio;       // lane favoured when both lanes request
  logic   req0;
  logic   req1;
  logic   req_any;
  logic   grant;
  logic   lane_sel;

  assign req0    = !fifo0_empty;
  assign req1    = !fifo1_empty;
  assign req_any = req0 || req1;

  // Grants are decided from the current empty flags, so a lane that drains
  // in the same cycle it is granted is still popped exactly once.
  assign grant    = reset && !pause && req_any;
  assign lane_sel = (req0 && req1) ? prio : (req0 ? LANE0 : LANE1);

  assign pop0 = grant && (lane_sel == LANE0);
  assign pop1 = grant && (lane_sel == LANE1);

  // Next state depends only on current requests and pause; any grant moves
  // the arbiter into RUN from either IDLE or HOLD.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (grant)                  state_nxt = ST_RUN;
        else if (req_any && pause)  state_nxt = ST_HOLD;
      end
      ST_RUN: begin
        if (!req_any)               state_nxt = ST_IDLE;
        else if (pause)             state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!req_any)               state_nxt = ST_IDLE;
        else if (grant)             state_nxt = ST_RUN;
      end
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state elements use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign idle = (state == ST_IDLE);

  // Output register. Idle slots present zero data, while lane_out keeps the
  // last served lane so a debug probe still shows who went last.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      lane_out  <= LANE0;
      prio      <= LANE0;
    end else if (grant) begin
      data_out  <= (lane_sel == LANE1) ? fifo1_data : fifo0_data;
      valid_out <= 1'b1;
      lane_out  <= lane_sel;
      prio      <= !lane_sel;
    end else begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end
  end

  contador_sat #(.CNT_WIDTH(CNT_WIDTH)) u_cnt0 (
    .clk   (clk),
    .reset (reset),
    .inc   (pop0),
    .count (grants0)
  );

  contador_sat #(.CNT_WIDTH(CNT_WIDTH)) u_cnt1 (
    .clk   (clk),
    .reset (reset),
    .inc   (pop1),
    .count (grants1)
  );

endmodule : arbitro_mux2x1

// File: tb/tb_arbitro_mux2x1.sv
// Self-checking bench for arbitro_mux2x1. Two instances share the stimulus:
// one with 8-bit counters and one with 2-bit counters to exercise saturation.
// The FIFOs are modelled as queues; the reference keeps "which lane went
// last" and derives every pop and registered output from the arbitration
// rules, then the bench runs directed scenarios followed by random traffic.
module tb_arbitro_mux2x1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fifo0_empty = 1'b1;
  logic       fifo1_empty = 1'b1;
  logic [7:0] fifo0_data = '0;
  logic [7:0] fifo1_data = '0;
  logic       pause = 1'b0;

  logic       pop0, pop1, valid_out, lane_out, idle;
  logic [7:0] data_out, grants0, grants1;
  logic       s_pop0, s_pop1, s_valid, s_lane, s_idle;
  logic [7:0] s_data;
  logic [1:0] s_grants0, s_grants1;

  arbitro_mux2x1 #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .fifo0_empty(fifo0_empty), .fifo1_empty(fifo1_empty),
    .fifo0_data(fifo0_data), .fifo1_data(fifo1_data), .pause(pause),
    .pop0(pop0), .pop1(pop1), .data_out(data_out), .valid_out(valid_out),
    .lane_out(lane_out), .idle(idle), .grants0(grants0), .grants1(grants1)
  );

  arbitro_mux2x1 #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut_s (
    .clk(clk), .reset(reset),
    .fifo0_empty(fifo0_empty), .fifo1_empty(fifo1_empty),
    .fifo0_data(fifo0_data), .fifo1_data(fifo1_data), .pause(pause),
    .pop0(s_pop0), .pop1(s_pop1), .data_out(s_data), .valid_out(s_valid),
    .lane_out(s_lane), .idle(s_idle), .grants0(s_grants0), .grants1(s_grants1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Environment FIFOs and reference model state.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         last_lane = 1;   // lane served most recently; the other one is favoured
  logic [7:0] m_data  = '0;
  logic       m_valid = 1'b0;
  logic       m_lane  = 1'b0;
  logic       m_idle  = 1'b1;
  int         n0 = 0;
  int         n1 = 0;

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: present the FIFO heads, check the combinational pops,
  // advance the model at the edge, then check the registered outputs.
  task automatic cycle();
    int want;
    @(negedge clk);
    fifo0_empty = (q0.size() == 0);
    fifo1_empty = (q1.size() == 0);
    fifo0_data  = fifo0_empty ? 8'($urandom) : q0[0];
    fifo1_data  = fifo1_empty ? 8'($urandom) : q1[0];
    #1;
    want = -1;
    if (reset && !pause) begin
      if (q0.size() > 0 && q1.size() > 0) want = (last_lane == 0) ? 1 : 0;
      else if (q0.size() > 0)             want = 0;
      else if (q1.size() > 0)             want = 1;
    end
    check("pop0",   32'(pop0),   32'(want == 0));
    check("pop1",   32'(pop1),   32'(want == 1));
    check("s_pop0", 32'(s_pop0), 32'(want == 0));
    check("s_pop1", 32'(s_pop1), 32'(want == 1));
    @(posedge clk);
    if (!reset) begin
      m_data = '0; m_valid = 1'b0; m_lane = 1'b0; m_idle = 1'b1;
      n0 = 0; n1 = 0; last_lane = 1;
    end else begin
      m_idle = (q0.size() == 0) && (q1.size() == 0);
      if (want == 0) begin
        m_data = q0.pop_front(); m_valid = 1'b1; m_lane = 1'b0; n0++; last_lane = 0;
      end else if (want == 1) begin
        m_data = q1.pop_front(); m_valid = 1'b1; m_lane = 1'b1; n1++; last_lane = 1;
      end else begin
        m_data = '0; m_valid = 1'b0;
      end
    end
    #1;
    check("data_out",  32'(data_out),  32'(m_data));
    check("valid_out", 32'(valid_out), 32'(m_valid));
    check("lane_out",  32'(lane_out),  32'(m_lane));
    check("idle",      32'(idle),      32'(m_idle));
    check("grants0",   32'(grants0),   32'(sat(n0, 255)));
    check("grants1",   32'(grants1),   32'(sat(n1, 255)));
    check("s_data",    32'(s_data),    32'(m_data));
    check("s_valid",   32'(s_valid),   32'(m_valid));
    check("s_lane",    32'(s_lane),    32'(m_lane));
    check("s_idle",    32'(s_idle),    32'(m_idle));
    check("s_grants0", 32'(s_grants0), 32'(sat(n0, 3)));
    check("s_grants1", 32'(s_grants1), 32'(sat(n1, 3)));
  endtask

  initial begin
    // Reset held for two cycles with both lanes holding data.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(8'hA0 + 8'(i));
      q1.push_back(8'hB0 + 8'(i));
    end
    cycle();
    cycle();

    // Both lanes busy: A0,B0,A1,B1,... with lane_out toggling.
    reset = 1'b1;
    repeat (9) cycle();

    // Only lane 0 has data: back-to-back pops, then idle.
    q0.push_back(8'h11); q0.push_back(8'h22); q0.push_back(8'h33);
    repeat (5) cycle();

    // Pause for three cycles mid-stream, then resume from the favoured lane.
    for (int i = 0; i < 4; i++) begin
      q0.push_back(8'hC0 + 8'(i));
      q1.push_back(8'hD0 + 8'(i));
    end
    cycle();
    pause = 1'b1;
    repeat (3) cycle();
    pause = 1'b0;
    repeat (3) cycle();

    // Reset pulse inside an alternating stream; lane 0 goes first afterwards.
    cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    repeat (8) cycle();

    // Lane 0 only, five words: the 2-bit counter saturates at 3.
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    q0 = {};
    q1 = {};
    for (int i = 0; i < 5; i++) q0.push_back(8'h50 + 8'(i));
    repeat (7) cycle();

    // Random traffic with random pause and occasional reset pulses.
    for (int i = 0; i < 600; i++) begin
      if (($urandom % 3 != 0) && q0.size() < 8) q0.push_back(8'($urandom));
      if (($urandom % 3 != 0) && q1.size() < 8) q1.push_back(8'($urandom));
      pause = ($urandom % 4 == 0);
      reset = ($urandom % 40 != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_arbitro_mux2x1
